// File: rtl/spi_recv_pkg.sv
// Shared definitions for the SPI-slave receiver.
//   - SPI_BYTE_W   : bits per SPI byte
//   - spi_state_e  : receiver FSM states (IDLE, SHIFT, FLUSH)
//   - rx_entry_t   : one FIFO entry, {last, data}
package spi_recv_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [1:0] {
        SPI_ST_IDLE  = 2'd0,
        SPI_ST_SHIFT = 2'd1,
        SPI_ST_FLUSH = 2'd2
    } spi_state_e;

    typedef struct packed {
        logic                  last;
        logic [SPI_BYTE_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/spi_recv_if.sv
// AXI4-Stream style byte channel from the SPI receiver to the CCU.
//   wdata  : received byte
//   wvalid : byte available
//   wready : sink accepts the byte
//   wlast  : last complete byte of a CS transaction
// Handshake: a beat transfers on a rising clock edge where wvalid and wready
// are both 1. Once wvalid is 1 it stays 1, with wdata/wlast unchanged, until
// that transfer happens (reset excepted). wready may change freely.
interface spi_recv_if;
    import spi_recv_pkg::*;

    logic [SPI_BYTE_W-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic                  wlast;

    modport master (output wdata, output wvalid, output wlast, input  wready);
    modport slave  (input  wdata, input  wvalid, input  wlast, output wready);
endinterface

// File: rtl/spi_recv_fifo.sv
// Synchronous first-word-fall-through FIFO for the SPI receiver.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (ignored when full unless pop is also set)
//   push_data  : entry to write
//   pop        : consume the head entry (ignored when empty)
//   pop_data   : head entry, zero while empty
//   full/empty : occupancy flags
module spi_recv_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/spi_recv.sv
// SPI-slave receiver (mode 0, oversampled in axi_aclk). Each CS-high
// transaction becomes one AXIS packet; wlast marks its final complete byte.
// Ports:
//   axi_aclk, axi_areset : clock, asynchronous active-high reset
//   spi_clk, spi_mosi    : SPI SCK / MOSI (asynchronous, synchronised here)
//   spi_cs               : chip select, active-high
//   axis                 : byte stream to the CCU (master modport)
//   rx_overflow          : one-cycle pulse when a byte is dropped on a full FIFO
//   drop_cnt             : saturating dropped-byte count (only with SPI_RECV_DROP_CNT_EN)
//   dbg_state            : current FSM state
// Optional feature macro: SPI_RECV_DROP_CNT_EN.
module spi_recv
    import spi_recv_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic          axi_aclk,
    input  logic          axi_areset,
    input  logic          spi_clk,
    input  logic          spi_mosi,
    input  logic          spi_cs,
    spi_recv_if.master    axis,
    output logic          rx_overflow,
`ifdef SPI_RECV_DROP_CNT_EN
    output logic [15:0]   drop_cnt,
`endif
    output spi_state_e    dbg_state
);
    // Reset asserts asynchronously, releases synchronously to axi_aclk.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) rst_sync_q <= 2'b11;
        else            rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic                   sclk_dly_q,  cs_dly_q;
    logic                   sync_sclk, sync_mosi, sync_cs;
    logic                   sclk_rise, cs_rise, cs_fall;

    spi_state_e             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [SPI_BYTE_W-1:0]  shreg_q, shreg_d;
    logic [SPI_BYTE_W-1:0]  pend_byte_q, pend_byte_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   push_q, push_d;
    rx_entry_t              push_entry_q, push_entry_d;
    logic                   rx_overflow_q, rx_overflow_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;
    logic [SPI_BYTE_W-1:0]  byte_next;

    logic                   fifo_full, fifo_empty, pop, drop;
    rx_entry_t              fifo_out;

    assign sync_sclk = sclk_sync_q[SYNC_STAGES-1];
    assign sync_mosi = mosi_sync_q[SYNC_STAGES-1];
    assign sync_cs   = cs_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sync_sclk & ~sclk_dly_q;
    assign cs_rise   = sync_cs   & ~cs_dly_q;
    assign cs_fall   = ~sync_cs  &  cs_dly_q;

    // Shift register contents after this SCK edge's bit is taken in.
    assign byte_next = (MSB_FIRST != 0) ? {shreg_q[SPI_BYTE_W-2:0], sync_mosi}
                                        : {sync_mosi, shreg_q[SPI_BYTE_W-1:1]};

    assign pop  = axis.wvalid & axis.wready;
    assign drop = push_q & fifo_full & ~pop;

    always_comb begin
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs};
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        pend_byte_d   = pend_byte_q;
        pend_vld_d    = pend_vld_q;
        push_d        = 1'b0;
        push_entry_d  = push_entry_q;
        rx_overflow_d = drop;
        drop_cnt_d    = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;

        case (state_q)
            SPI_ST_IDLE: begin
                if (cs_rise) begin
                    bit_cnt_d  = 3'd0;
                    pend_vld_d = 1'b0;
                    state_d    = SPI_ST_SHIFT;
                end
            end
            SPI_ST_SHIFT: begin
                // A byte completing in the same cycle as cs_fall is held
                // first, so FLUSH sees it and tags it last.
                if (sclk_rise) begin
                    shreg_d   = byte_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (pend_vld_q) begin
                            push_d       = 1'b1;
                            push_entry_d = '{last: 1'b0, data: pend_byte_q};
                        end
                        pend_byte_d = byte_next;
                        pend_vld_d  = 1'b1;
                    end
                end
                if (cs_fall) state_d = SPI_ST_FLUSH;
            end
            SPI_ST_FLUSH: begin
                // Any partial byte is dropped by clearing bit_cnt.
                if (pend_vld_q) begin
                    push_d       = 1'b1;
                    push_entry_d = '{last: 1'b1, data: pend_byte_q};
                end
                pend_vld_d = 1'b0;
                bit_cnt_d  = 3'd0;
                state_d    = SPI_ST_IDLE;
            end
            default: state_d = SPI_ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge rst_int) begin
        if (rst_int) begin
            sclk_sync_q   <= '0;
            mosi_sync_q   <= '0;
            cs_sync_q     <= '0;
            sclk_dly_q    <= 1'b0;
            cs_dly_q      <= 1'b0;
            state_q       <= SPI_ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shreg_q       <= '0;
            pend_byte_q   <= '0;
            pend_vld_q    <= 1'b0;
            push_q        <= 1'b0;
            push_entry_q  <= '0;
            rx_overflow_q <= 1'b0;
            drop_cnt_q    <= 16'd0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            cs_sync_q     <= cs_sync_d;
            sclk_dly_q    <= sync_sclk;
            cs_dly_q      <= sync_cs;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            pend_byte_q   <= pend_byte_d;
            pend_vld_q    <= pend_vld_d;
            push_q        <= push_d;
            push_entry_q  <= push_entry_d;
            rx_overflow_q <= rx_overflow_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    spi_recv_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SPI_BYTE_W + 1)
    ) u_fifo (
        .clk       (axi_aclk),
        .rst       (rst_int),
        .push      (push_q),
        .push_data (push_entry_q),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign axis.wvalid = ~fifo_empty;
    assign axis.wdata  = fifo_out.data;
    assign axis.wlast  = fifo_out.last;
    assign rx_overflow = rx_overflow_q;
    assign dbg_state   = state_q;
`ifdef SPI_RECV_DROP_CNT_EN
    assign drop_cnt    = drop_cnt_q;
`else
    // Counter logic is left unconnected and trimmed without the feature.
    logic unused_drop;
    assign unused_drop = ^drop_cnt_q;
`endif
endmodule

// File: tb/tb_spi_recv.sv
// Bench for spi_recv. Two receivers share the SPI pins: dut A (MSB first,
// 4-entry FIFO, sink stalls under bench control) and dut B (LSB first,
// 16-entry FIFO, sink always ready). Expected beats are queued as bytes are
// sent; a negedge monitor pops and compares every handshake.
module tb_spi_recv;
    import spi_recv_pkg::*;

    localparam int DEPTH_A = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sclk, mosi, cs;
    logic       ovf_a, ovf_b;
    spi_state_e st_a, st_b;
`ifdef SPI_RECV_DROP_CNT_EN
    logic [15:0] dc_a, dc_b;
`endif

    spi_recv_if axa();
    spi_recv_if axb();

    spi_recv #(.FIFO_DEPTH(DEPTH_A), .SYNC_STAGES(2), .MSB_FIRST(1)) u_a (
        .axi_aclk(clk), .axi_areset(rst), .spi_clk(sclk), .spi_mosi(mosi),
        .spi_cs(cs), .axis(axa), .rx_overflow(ovf_a),
`ifdef SPI_RECV_DROP_CNT_EN
        .drop_cnt(dc_a),
`endif
        .dbg_state(st_a));

    spi_recv #(.FIFO_DEPTH(16), .SYNC_STAGES(2), .MSB_FIRST(0)) u_b (
        .axi_aclk(clk), .axi_areset(rst), .spi_clk(sclk), .spi_mosi(mosi),
        .spi_cs(cs), .axis(axb), .rx_overflow(ovf_b),
`ifdef SPI_RECV_DROP_CNT_EN
        .drop_cnt(dc_b),
`endif
        .dbg_state(st_b));

    // Scoreboard
    logic [8:0] exp_q_a[$];
    logic [8:0] exp_q_b[$];
    int         total = 0;
    int         bad = 0;
    int         occ_a = 0;
    int         ovf_cnt_a = 0;
    int         ovf_cnt_b = 0;
    logic       stall_a = 1'b0;
    logic [8:0] stall_val_a = '0;
    logic       pend_vld = 1'b0;
    logic [7:0] pend_byte = '0;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Dut A models FIFO capacity while its sink is stalled; dut B never fills.
    task automatic model_push(input logic last, input logic [7:0] b);
        if (occ_a < DEPTH_A) begin
            exp_q_a.push_back({last, b});
            occ_a++;
        end
        exp_q_b.push_back({last, rev8(b)});
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                total++;
                if (!axa.wvalid || {axa.wlast, axa.wdata} !== stall_val_a) begin
                    bad++;
                    $display("FAIL stable_a got=%0b/%0h expected=1/%0h", axa.wvalid,
                             {axa.wlast, axa.wdata}, stall_val_a);
                end
            end
            if (axa.wvalid && axa.wready) begin
                total++;
                if (exp_q_a.size() == 0) begin
                    bad++;
                    $display("FAIL beat_a got=%0h expected=none", {axa.wlast, axa.wdata});
                end else begin
                    logic [8:0] e;
                    e = exp_q_a.pop_front();
                    occ_a--;
                    if ({axa.wlast, axa.wdata} !== e) begin
                        bad++;
                        $display("FAIL beat_a got=%0h expected=%0h", {axa.wlast, axa.wdata}, e);
                    end
                end
            end
            if (axb.wvalid && axb.wready) begin
                total++;
                if (exp_q_b.size() == 0) begin
                    bad++;
                    $display("FAIL beat_b got=%0h expected=none", {axb.wlast, axb.wdata});
                end else begin
                    logic [8:0] e;
                    e = exp_q_b.pop_front();
                    if ({axb.wlast, axb.wdata} !== e) begin
                        bad++;
                        $display("FAIL beat_b got=%0h expected=%0h", {axb.wlast, axb.wdata}, e);
                    end
                end
            end
            stall_a     = axa.wvalid && !axa.wready;
            stall_val_a = {axa.wlast, axa.wdata};
            if (ovf_a) ovf_cnt_a++;
            if (ovf_b) ovf_cnt_b++;
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sclk = 1'b0;
        mosi = b;
        tick(4);
        sclk = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        if (pend_vld) model_push(1'b0, pend_byte);
        pend_byte = b;
        pend_vld  = 1'b1;
    endtask

    task automatic cs_on();
        sclk = 1'b0;
        cs   = 1'b1;
        tick(4);
        pend_vld = 1'b0;
    endtask

    task automatic cs_off();
        sclk = 1'b0;
        tick(4);
        cs = 1'b0;
        if (pend_vld) model_push(1'b1, pend_byte);
        pend_vld = 1'b0;
        tick(8);
    endtask

    // Last byte whose 8th SCK edge coincides with CS falling.
    task automatic send_byte_with_cs_fall(input logic [7:0] b);
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        sclk = 1'b0;
        mosi = b[0];
        tick(4);
        sclk = 1'b1;
        cs   = 1'b0;
        if (pend_vld) model_push(1'b0, pend_byte);
        model_push(1'b1, b);
        pend_vld = 1'b0;
        tick(4);
        sclk = 1'b0;
        tick(8);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && n < 400) begin
            tick(1);
            n++;
        end
        check(name, exp_q_a.size() + exp_q_b.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        cs = 1'b0;
        sclk = 1'b0;
        mosi = 1'b0;
        axa.wready = 1'b1;
        axb.wready = 1'b1;
        tick(3);
        check("rst_wvalid", axa.wvalid, 0);
        check("rst_wlast", axa.wlast, 0);
        check("rst_wdata", axa.wdata, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_state", st_a, SPI_ST_IDLE);
        rst = 1'b0;
        tick(5);

        // Two full bytes, second tagged last
        cs_on();
        send_byte(8'hA5);
        send_byte(8'h3C);
        cs_off();
        drain("drain_two_bytes");

        // Single byte: bits 1,0,0,0,0,0,0,0 -> A sees 0x80, B (LSB first) sees 0x01
        cs_on();
        send_byte(8'h80);
        cs_off();
        drain("drain_single");

        // Two bytes plus five stray SCK edges: partial bits discarded
        cs_on();
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        cs_off();
        drain("drain_partial");

        // Stalled sink, 7 bytes into a 4-deep FIFO
        axa.wready = 1'b0;
        ovf_cnt_a = 0;
        cs_on();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        cs_off();
        tick(20);
        check("ovf_pulses", ovf_cnt_a, 3);
        check("ovf_hold_valid", axa.wvalid, 1);
        check("ovf_hold_head", {axa.wlast, axa.wdata}, 9'h011);
`ifdef SPI_RECV_DROP_CNT_EN
        check("drop_cnt", dc_a, 3);
        check("drop_cnt_b", dc_b, 0);
`endif
        axa.wready = 1'b1;
        drain("drain_overflow");
        check("ovf_pulses_b", ovf_cnt_b, 0);

        // CS falls on the 8th SCK edge of the last byte
        cs_on();
        send_byte(8'h9E);
        send_byte_with_cs_fall(8'h47);
        drain("drain_same_cycle");

        // Reset mid-byte with beats queued
        axa.wready = 1'b0;
        cs_on();
        send_byte(8'hD1);
        send_byte(8'hE2);
        send_byte(8'hF3);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        tick(6);
        check("pre_rst_valid", axa.wvalid, 1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", axa.wvalid, 0);
        exp_q_a.delete();
        exp_q_b.delete();
        occ_a = 0;
        pend_vld = 1'b0;
        cs = 1'b0;
        sclk = 1'b0;
        tick(3);
        rst = 1'b0;
        axa.wready = 1'b1;
        tick(5);
        check("post_rst_valid", axa.wvalid, 0);
        check("post_rst_state", st_a, SPI_ST_IDLE);
`ifdef SPI_RECV_DROP_CNT_EN
        check("post_rst_drop_cnt", dc_a, 0);
`endif
        cs_on();
        send_byte(8'h5A);
        send_byte(8'hC3);
        cs_off();
        drain("drain_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
